// File: rtl/spi_clk_pkg.sv
// Shared types and helpers for the SPI clock generator.
// The lock counter is built only when SPI_CLK_GEN_LOCK_EN is defined.
package spi_clk_pkg;

    localparam int SPI_DIV_W = 8;

    typedef struct packed {
        logic [SPI_DIV_W-1:0] half_div;
        logic                 cpol;
    } spi_clk_cfg_t;

    // A half-period of zero would stall the counter, so it runs as one.
    function automatic logic [31:0] eff_div(input logic [31:0] half_div);
        logic [31:0] eff_v;
        if (half_div == 32'd0) begin
            eff_v = 32'd1;
        end else begin
            eff_v = half_div;
        end
        return eff_v;
    endfunction

endpackage

// File: rtl/spi_clk_chan.sv
// One SCK channel: half-period counter, phase, edge strobes and lock indication.
// Macro SPI_CLK_GEN_LOCK_EN builds the full-period lock counter.
module spi_clk_chan
    import spi_clk_pkg::*;
#(
    parameter int DIV_W            = 8,
    parameter int DEFAULT_HALF_DIV = 4,
    parameter int LOCK_PERIODS     = 4
) (
    input  logic             clk_in1,
    input  logic             reset,
    input  logic             enable,
    input  logic             apply,
    input  logic [DIV_W-1:0] apply_half_div,
    input  logic             apply_cpol,
    output logic             period_end,
    output logic             sck,
    output logic             sck_b,
    output logic             rise_stb,
    output logic             fall_stb,
    output logic             locked
);

    logic [DIV_W-1:0] cnt_r;
    logic [DIV_W-1:0] half_div_r;
    logic             phase_r;
    logic             cpol_r;
    logic             sck_r;
    logic             sck_b_r;
    logic             rise_r;
    logic             fall_r;
    logic             locked_r;

    logic [DIV_W-1:0] eff_s;
    logic [DIV_W-1:0] cnt_s;
    logic [DIV_W-1:0] half_div_s;
    logic             phase_s;
    logic             cpol_s;
    logic             term_s;
    logic             sck_s;

    // Terminal count and full-period detection for the current divider.
    always_comb begin
        eff_s      = DIV_W'(eff_div(32'(half_div_r)));
        term_s     = (cnt_r == (eff_s - DIV_W'(1'b1)));
        period_end = enable & phase_r & term_s;
    end

    // Next channel state; an apply overrides both the terminal toggle and disable.
    always_comb begin
        cnt_s      = cnt_r;
        phase_s    = phase_r;
        half_div_s = half_div_r;
        cpol_s     = cpol_r;
        if (apply) begin
            half_div_s = apply_half_div;
            cpol_s     = apply_cpol;
            cnt_s      = '0;
            phase_s    = 1'b0;
        end else if (!enable) begin
            cnt_s   = '0;
            phase_s = 1'b0;
        end else if (term_s) begin
            cnt_s   = '0;
            phase_s = ~phase_r;
        end else begin
            cnt_s = cnt_r + DIV_W'(1'b1);
        end
        sck_s = phase_s ^ cpol_s;
    end

    // Channel registers; strobes compare the new SCK level with the old one.
    always_ff @(posedge clk_in1) begin
        if (reset) begin
            cnt_r      <= '0;
            phase_r    <= 1'b0;
            half_div_r <= DIV_W'(DEFAULT_HALF_DIV);
            cpol_r     <= 1'b0;
            sck_r      <= 1'b0;
            sck_b_r    <= 1'b1;
            rise_r     <= 1'b0;
            fall_r     <= 1'b0;
        end else begin
            cnt_r      <= cnt_s;
            phase_r    <= phase_s;
            half_div_r <= half_div_s;
            cpol_r     <= cpol_s;
            sck_r      <= sck_s;
            sck_b_r    <= ~sck_s;
            rise_r     <= sck_s & ~sck_r;
            fall_r     <= ~sck_s & sck_r;
        end
    end

`ifdef SPI_CLK_GEN_LOCK_EN
    localparam int LOCK_W = (LOCK_PERIODS < 1) ? 1 : $clog2(LOCK_PERIODS + 1);

    logic [LOCK_W-1:0] lock_cnt_r;
    logic [LOCK_W-1:0] lock_cnt_s;

    // Count completed full periods, saturating at the lock threshold.
    always_comb begin
        lock_cnt_s = lock_cnt_r;
        if (apply || !enable) begin
            lock_cnt_s = '0;
        end else if (phase_r && term_s && (lock_cnt_r != LOCK_W'(LOCK_PERIODS))) begin
            lock_cnt_s = lock_cnt_r + LOCK_W'(1'b1);
        end else begin
            lock_cnt_s = lock_cnt_r;
        end
    end

    // Lock counter and lock flag registers.
    always_ff @(posedge clk_in1) begin
        if (reset) begin
            lock_cnt_r <= '0;
            locked_r   <= 1'b0;
        end else begin
            lock_cnt_r <= lock_cnt_s;
            locked_r   <= (lock_cnt_s == LOCK_W'(LOCK_PERIODS));
        end
    end
`else
    // Without a lock counter the channel reports locked once reset releases.
    always_ff @(posedge clk_in1) begin
        if (reset) begin
            locked_r <= 1'b0;
        end else begin
            locked_r <= 1'b1;
        end
    end
`endif

    assign sck      = sck_r;
    assign sck_b    = sck_b_r;
    assign rise_stb = rise_r;
    assign fall_stb = fall_r;
    assign locked   = locked_r;

endmodule

// File: rtl/spi_clk_gen.sv
// NUM_CH independent SPI clocks with a shared single-slot reconfiguration port.
// Macro SPI_CLK_GEN_LOCK_EN enables per-channel lock counting.
module spi_clk_gen
    import spi_clk_pkg::*;
#(
    parameter int NUM_CH           = 2,
    parameter int DIV_W            = 8,
    parameter int DEFAULT_HALF_DIV = 4,
    parameter int LOCK_PERIODS     = 4,
    localparam int CH_W            = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_in1,
    input  logic              reset,
    input  logic [NUM_CH-1:0] enable,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_half_div,
    input  logic              cfg_cpol,
    output logic [NUM_CH-1:0] sck,
    output logic [NUM_CH-1:0] sck_b,
    output logic [NUM_CH-1:0] rise_stb,
    output logic [NUM_CH-1:0] fall_stb,
    output logic [NUM_CH-1:0] locked
);

    logic              pend_valid_r;
    logic [CH_W-1:0]   pend_ch_r;
    logic [DIV_W-1:0]  pend_half_div_r;
    logic              pend_cpol_r;
    logic              cfg_ready_r;

    logic              accept_s;
    logic              ch_ok_s;
    logic              apply_any_s;
    logic [NUM_CH-1:0] apply_s;
    logic [NUM_CH-1:0] period_end_s;

    // Handshake decode; out-of-range channels are accepted but never pended.
    always_comb begin
        accept_s = cfg_valid & cfg_ready_r;
        ch_ok_s  = (32'(cfg_ch) < NUM_CH);
    end

    // Apply the pending entry when its channel is idle or closes a full period.
    always_comb begin
        apply_s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (pend_valid_r && (32'(pend_ch_r) == i) && (!enable[i] || period_end_s[i])) begin
                apply_s[i] = 1'b1;
            end else begin
                apply_s[i] = 1'b0;
            end
        end
        apply_any_s = |apply_s;
    end

    // Pending slot and ready flag; ready returns one edge after the slot empties.
    always_ff @(posedge clk_in1) begin
        if (reset) begin
            pend_valid_r    <= 1'b0;
            pend_ch_r       <= '0;
            pend_half_div_r <= '0;
            pend_cpol_r     <= 1'b0;
            cfg_ready_r     <= 1'b1;
        end else begin
            if (accept_s) begin
                pend_valid_r    <= ch_ok_s;
                pend_ch_r       <= cfg_ch;
                pend_half_div_r <= cfg_half_div;
                pend_cpol_r     <= cfg_cpol;
            end else if (apply_any_s) begin
                pend_valid_r <= 1'b0;
            end else begin
                pend_valid_r <= pend_valid_r;
            end
            cfg_ready_r <= ~pend_valid_r & ~accept_s;
        end
    end

    assign cfg_ready = cfg_ready_r;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        spi_clk_chan #(
            .DIV_W            (DIV_W),
            .DEFAULT_HALF_DIV (DEFAULT_HALF_DIV),
            .LOCK_PERIODS     (LOCK_PERIODS)
        ) u_chan (
            .clk_in1        (clk_in1),
            .reset          (reset),
            .enable         (enable[g]),
            .apply          (apply_s[g]),
            .apply_half_div (pend_half_div_r),
            .apply_cpol     (pend_cpol_r),
            .period_end     (period_end_s[g]),
            .sck            (sck[g]),
            .sck_b          (sck_b[g]),
            .rise_stb       (rise_stb[g]),
            .fall_stb       (fall_stb[g]),
            .locked         (locked[g])
        );
    end

endmodule

// File: tb/tb_spi_clk_gen.sv
// Directed self-checking bench for spi_clk_gen (default parameters).
// Lock checks follow SPI_CLK_GEN_LOCK_EN.
module tb_spi_clk_gen;

    logic       clk_in1 = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] enable = 2'b00;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [0:0] cfg_ch = 1'b0;
    logic [7:0] cfg_half_div = 8'd0;
    logic       cfg_cpol = 1'b0;
    logic [1:0] sck;
    logic [1:0] sck_b;
    logic [1:0] rise_stb;
    logic [1:0] fall_stb;
    logic [1:0] locked;

    int checks = 0;
    int failures = 0;

    spi_clk_gen #(
        .NUM_CH(2), .DIV_W(8), .DEFAULT_HALF_DIV(4), .LOCK_PERIODS(4)
    ) dut (
        .clk_in1(clk_in1), .reset(reset), .enable(enable),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
        .cfg_half_div(cfg_half_div), .cfg_cpol(cfg_cpol),
        .sck(sck), .sck_b(sck_b), .rise_stb(rise_stb), .fall_stb(fall_stb),
        .locked(locked)
    );

    always #5 clk_in1 = ~clk_in1;

    task automatic tick();
        @(posedge clk_in1);
        @(negedge clk_in1);
    endtask

    task automatic test_reset();
        logic [1:0] exp_locked;
        reset = 1'b1; enable = 2'b00;
        cfg_valid = 1'b1; cfg_ch = 1'b1; cfg_half_div = 8'd0; cfg_cpol = 1'b1;
        tick(); tick();
        checks++;
        if ({sck, sck_b, rise_stb, fall_stb} !== 8'b00_11_00_00) begin
            failures++;
            $display("FAIL reset_outputs: got %b want %b", {sck, sck_b, rise_stb, fall_stb}, 8'b00_11_00_00);
        end
        checks++;
        if (locked !== 2'b00) begin
            failures++; $display("FAIL reset_locked: got %b want 00", locked);
        end
        checks++;
        if (cfg_ready !== 1'b1) begin
            failures++; $display("FAIL reset_ready: got %b want 1", cfg_ready);
        end
        cfg_valid = 1'b0; reset = 1'b0;
        tick();
`ifdef SPI_CLK_GEN_LOCK_EN
        exp_locked = 2'b00;
`else
        exp_locked = 2'b11;
`endif
        checks++;
        if (locked !== exp_locked) begin
            failures++; $display("FAIL release_locked: got %b want %b", locked, exp_locked);
        end
        checks++;
        if (sck !== 2'b00 || cfg_ready !== 1'b1) begin
            failures++; $display("FAIL reset_req_ignored: sck=%b ready=%b want sck=00 ready=1", sck, cfg_ready);
        end
    endtask

    task automatic test_enable_ch0();
        logic e, prev, r, f;
        prev = 1'b0;
        enable = 2'b01;
        for (int k = 0; k <= 18; k++) begin
            tick();
            e = 1'(((k + 1) >> 2) & 1);
            r = e & ~prev;
            f = ~e & prev;
            checks++;
            if ({sck, sck_b, rise_stb, fall_stb} !== {1'b0, e, 1'b1, ~e, 1'b0, r, 1'b0, f}) begin
                failures++;
                $display("FAIL enable_ch0 k=%0d: got %b want %b", k,
                         {sck, sck_b, rise_stb, fall_stb}, {1'b0, e, 1'b1, ~e, 1'b0, r, 1'b0, f});
            end
            prev = e;
        end
        enable = 2'b00;
        tick();
        checks++;
        if ({sck, rise_stb, fall_stb} !== 6'b0) begin
            failures++; $display("FAIL disable_low: got %b want 000000", {sck, rise_stb, fall_stb});
        end
    endtask

    task automatic test_cfg_idle_ch1();
        checks++;
        if (cfg_ready !== 1'b1) begin
            failures++; $display("FAIL idle_ready_pre: got %b want 1", cfg_ready);
        end
        cfg_valid = 1'b1; cfg_ch = 1'b1; cfg_half_div = 8'd0; cfg_cpol = 1'b0;
        tick();
        cfg_valid = 1'b0;
        checks++;
        if (cfg_ready !== 1'b0) begin
            failures++; $display("FAIL idle_ready_a1: got %b want 0", cfg_ready);
        end
        tick();
        checks++;
        if (cfg_ready !== 1'b0) begin
            failures++; $display("FAIL idle_ready_a2: got %b want 0", cfg_ready);
        end
        tick();
        checks++;
        if (cfg_ready !== 1'b1) begin
            failures++; $display("FAIL idle_ready_a3: got %b want 1", cfg_ready);
        end
        enable = 2'b10;
        for (int k = 0; k <= 5; k++) begin
            tick();
            checks++;
            if ({sck, rise_stb, fall_stb} !== {(k % 2 == 0), 1'b0, (k % 2 == 0), 1'b0, (k % 2 == 1), 1'b0}) begin
                failures++;
                $display("FAIL div0_ch1 k=%0d: got %b want %b", k, {sck, rise_stb, fall_stb},
                         {(k % 2 == 0), 1'b0, (k % 2 == 0), 1'b0, (k % 2 == 1), 1'b0});
            end
        end
        enable = 2'b00;
        tick();
    endtask

    task automatic test_reconfig_running();
        logic [14:0] sck_tab;
        logic prev, r, f, rdy;
        sck_tab = 15'b110011001111000;
        prev = 1'b0;
        enable = 2'b01;
        for (int k = 0; k <= 14; k++) begin
            tick();
            if (k == 5) cfg_valid = 1'b0;
            r = sck_tab[k] & ~prev;
            f = ~sck_tab[k] & prev;
            rdy = (k < 5) || (k >= 8);
            checks++;
            if ({sck[0], rise_stb[0], fall_stb[0], cfg_ready} !== {sck_tab[k], r, f, rdy}) begin
                failures++;
                $display("FAIL reconfig_run k=%0d: got sck/rise/fall/ready %b want %b", k,
                         {sck[0], rise_stb[0], fall_stb[0], cfg_ready}, {sck_tab[k], r, f, rdy});
            end
            prev = sck_tab[k];
            if (k == 4) begin
                cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_half_div = 8'd2; cfg_cpol = 1'b0;
            end
        end
        enable = 2'b00;
        tick();
        checks++;
        if ({sck, rise_stb, fall_stb} !== 6'b00_00_01) begin
            failures++; $display("FAIL drop_mid_high: got %b want 000001", {sck, rise_stb, fall_stb});
        end
    endtask

    task automatic test_cpol();
        cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_half_div = 8'd2; cfg_cpol = 1'b1;
        tick();
        cfg_valid = 1'b0;
        checks++;
        if (sck !== 2'b00) begin
            failures++; $display("FAIL cpol_before_apply: got %b want 00", sck);
        end
        tick();
        checks++;
        if ({sck, sck_b, rise_stb, fall_stb} !== 8'b01_10_01_00) begin
            failures++;
            $display("FAIL cpol_apply: got %b want 01100100", {sck, sck_b, rise_stb, fall_stb});
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({sck, rise_stb, fall_stb, cfg_ready} !== 7'b01_00_00_1) begin
                failures++;
                $display("FAIL cpol_idle_high k=%0d: got %b want 0100001", k, {sck, rise_stb, fall_stb, cfg_ready});
            end
        end
    endtask

    task automatic test_lock();
        logic exp_l;
        reset = 1'b1;
        tick();
        reset = 1'b0; enable = 2'b01;
`ifdef SPI_CLK_GEN_LOCK_EN
        for (int k = 0; k <= 40; k++) begin
            tick();
            if (k == 32) cfg_valid = 1'b0;
            exp_l = (k >= 31) && (k <= 38);
            checks++;
            if (locked[0] !== exp_l) begin
                failures++; $display("FAIL lock k=%0d: got %b want %b", k, locked[0], exp_l);
            end
            if (k == 31) begin
                cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_half_div = 8'd4; cfg_cpol = 1'b0;
            end
        end
`else
        exp_l = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if (locked !== {exp_l, exp_l}) begin
                failures++; $display("FAIL lock_static k=%0d: got %b want 11", k, locked);
            end
        end
`endif
        enable = 2'b00;
        tick();
    endtask

    task automatic test_reset_mid();
        logic e;
        reset = 1'b1;
        tick();
        reset = 1'b0; enable = 2'b11;
        cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_half_div = 8'd3; cfg_cpol = 1'b1;
        tick();
        cfg_valid = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
        checks++;
        if ({sck, sck_b, rise_stb, fall_stb, locked, cfg_ready} !== 11'b00_11_00_00_00_1) begin
            failures++;
            $display("FAIL mid_reset: got %b want 00110000001", {sck, sck_b, rise_stb, fall_stb, locked, cfg_ready});
        end
        reset = 1'b0;
        for (int k = 0; k <= 12; k++) begin
            tick();
            e = 1'(((k + 1) >> 2) & 1);
            checks++;
            if ({sck, cfg_ready} !== {e, e, 1'b1}) begin
                failures++;
                $display("FAIL post_reset_run k=%0d: got sck/ready %b want %b", k, {sck, cfg_ready}, {e, e, 1'b1});
            end
        end
        enable = 2'b00;
        tick();
    endtask

    initial begin
        test_reset();
        test_enable_ch0();
        test_cfg_idle_ch1();
        test_reconfig_running();
        test_cpol();
        test_lock();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_clk_gen.md
# spi_clk_gen

Parametrised fabric clock generator for the SPI memory programmer, sitting between the system clock domain and the SPI shifters. From one `clk_in1` it derives `NUM_CH` independent SPI clocks, each with a programmable divider and polarity. Each channel also provides one-cycle edge strobes for the shift logic and a per-channel lock indication. Dividers and polarity are reprogrammable at run time, glitch-free, through a valid/ready handshake.

## Interface
Parameters:
- `NUM_CH`, 2: number of independent SCK channels (1..8).
- `DIV_W`, 8: width of the half-period divider.
- `DEFAULT_HALF_DIV`, 4: half-period loaded at reset, in `clk_in1` cycles.
- `LOCK_PERIODS`, 4: full SCK periods before `locked` asserts.

Ports:
- `clk_in1`  in  1  system clock; sole clock of the block.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  NUM_CH  per-channel run enable.
- `cfg_valid`  in  1  reconfiguration request.
- `cfg_ready`  out  1  reconfiguration slot free.
- `cfg_ch`  in  max(1,$clog2(NUM_CH))  target channel.
- `cfg_half_div`  in  DIV_W  new half-period; 0 is treated as 1.
- `cfg_cpol`  in  1  new idle level.
- `sck`  out  NUM_CH  generated SPI clocks.
- `sck_b`  out  NUM_CH  complement of `sck`.
- `rise_stb`  out  NUM_CH  pulse in the cycle `sck` has just gone 0->1.
- `fall_stb`  out  NUM_CH  pulse in the cycle `sck` has just gone 1->0.
- `locked`  out  NUM_CH  channel running stably with its current configuration.

## Operation
- Channel state: `cnt` (DIV_W), `phase`, `half_div`, `cpol`, lock counter. All outputs are registered.
- `sck = phase ^ cpol`; `sck_b = ~sck`. Effective period is `2*max(half_div,1)` cycles; duty cycle is exactly 50%.
- On an edge with `enable[i]`=1: if `cnt == eff_div-1`, then toggle `phase` and set `cnt` to 0. Otherwise increment `cnt`.
- On an edge with `enable[i]`=0: set `cnt` and `phase` to 0. `sck` idles at `cpol` and no strobes are generated.
- Strobes are derived from the actual change of `sck` level, never from `phase` alone. A `cpol` change therefore produces the matching strobe.
- Reconfiguration uses a single pending slot:
  - The request is accepted on `cfg_valid && cfg_ready`. `cfg_ready` drops on the next edge.
  - The pending configuration is applied on the first edge where the target channel is disabled, or where it completes a full period (`phase`=1 and terminal `cnt`).
  - On apply, `cnt` and `phase` are set to 0. `cfg_ready` rises one edge later.
  - If `cfg_ch >= NUM_CH`, the request is accepted and discarded, and `cfg_ready` returns after one cycle.
- Lock behaviour depends on the macro; see Configuration.

## Timing
- Reset values:
  - `sck`=0, `sck_b`=1, strobes 0, `locked`=0, `cfg_ready`=1.
  - Every channel holds `half_div=DEFAULT_HALF_DIV`, `cpol`=0, `cnt=phase=0`.
  - A pending configuration is discarded.
- Requests presented while `reset` is high are ignored.
- With `enable[i]` first sampled high at edge E0, the first `sck` toggle occurs at edge E(eff_div-1). Subsequent toggles follow every eff_div edges.
- Strobe latency is 0 relative to the registered `sck`: the strobe and the new level appear after the same edge.
- If `enable` drops mid-period, `sck` returns to `cpol` on the next edge. A `fall_stb` (CPOL=0) or `rise_stb` (CPOL=1) fires only if the level actually changes.
- If an apply coincides with the terminal count, the new configuration wins and `phase` does not toggle.
- If an apply and a deassertion of `enable` occur on the same edge, the configuration is applied and the channel idles at the new `cpol`.
- A mid-operation reset returns all channels to reset values on that edge, with no partial period completed.

## Configuration
- Macro: `SPI_CLK_GEN_LOCK_EN`.
- Defined:
  - A per-channel counter counts completed full periods while the channel is enabled.
  - `locked[i]` asserts on the edge where the count reaches `LOCK_PERIODS` and then saturates.
  - The counter is cleared, and `locked[i]` dropped, by reset, an apply, or `enable[i]`=0.
- Undefined:
  - No counter is built.
  - `locked[i]` is 1 from the first edge after reset releases and stays 1 until the next reset.

## Structure
- Package `spi_clk_pkg` holds:
  - `typedef struct packed {logic [DIV_W-1:0] half_div; logic cpol;} spi_clk_cfg_t`, parameterised via a package constant `SPI_DIV_W`=8.
  - Function `eff_div()`, which implements the 0->1 rule.
- Sub-module `spi_clk_chan` implements one channel: counter, phase, strobes and the lock counter. The top level generates `NUM_CH` instances and implements the shared pending slot and `cfg_ready`.

## Test plan
- Reset with defaults, then enable ch0 with no reconfiguration: `sck[0]` first rises at edge E3, period is 8 cycles, `rise_stb`/`fall_stb` are one cycle wide, `sck[1]`=0.
- Request `cfg_ch=1, half_div=0, cpol=0` on an idle channel: applied next edge, `cfg_ready` back after 2 cycles. Ch1 then toggles every cycle (period 2).
- Request `half_div=2` on running ch0 mid-period: the old period completes unchanged, the new 4-cycle period starts, and no runt pulse appears on `sck[0]`.
- With `cpol` switching 0->1 on idle ch0: `sck[0]` goes 1, one `rise_stb`, and the channel then idles high.
- With `SPI_CLK_GEN_LOCK_EN` defined and `LOCK_PERIODS`=4, divider 4: `locked[0]` rises exactly 32 cycles after enable, and drops on a reconfiguration apply.
- Assert `reset` for one cycle while both channels are running and a configuration is pending: all outputs return to reset values on that edge, and the pending configuration is never applied.
